// File: rtl/mem_pkg.sv
// Shared types and helpers for the MIPS data-memory unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmu_state_t;

  // Only the two low address bits matter for natural alignment.
  function automatic logic is_aligned(logic [1:0] addr, mem_size_t size);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr[0];
      default: ok = (addr == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte mask / shifted data, load extract and extend.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign shamt   = {lane_i, 3'b000};
  assign rshift  = rword_i >> shamt;
  assign wdata_o = wdata_i << shamt;

  always_comb begin
    wmask_o = 4'b1111;
    rdata_o = rshift;
    case (mem_size_t'(size_i))
      SZ_BYTE: begin
        wmask_o = 4'b0001 << lane_i;
        rdata_o = {{24{~is_unsigned_i & rshift[7]}}, rshift[7:0]};
      end
      SZ_HALF: begin
        wmask_o = 4'b0011 << lane_i;
        rdata_o = {{16{~is_unsigned_i & rshift[15]}}, rshift[15:0]};
      end
      default: begin
        wmask_o = 4'b1111;
        rdata_o = rshift;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data memory with valid/ready requests and a fixed-latency response; commits at acceptance.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("data_mem_unit: LATENCY must be >= 1");
  end

  logic [31:0] mem [0:MEM_DEPTH-1];

  dmu_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept, in_range, access_ok;
  logic [IdxW-1:0] idx;
  logic [3:0]      wmask;
  logic [31:0]     wdata_sh, rdata_ext;

  assign in_range  = {2'b00, req_addr[31:2]} < MEM_DEPTH;
  assign idx       = req_addr[IdxW+1:2];
  assign access_ok = in_range && is_aligned(req_addr[1:0], mem_size_t'(req_size));

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_ready & req_valid;

  mem_lane_align u_align (
    .size_i        (req_size),
    .is_unsigned_i (req_unsigned),
    .lane_i        (req_addr[1:0]),
    .wdata_i       (req_wdata),
    .rword_i       (mem[idx]),
    .wmask_o       (wmask),
    .wdata_o       (wdata_sh),
    .rdata_o       (rdata_ext)
  );

  // WAIT spans LATENCY-1 cycles: the counter runs LATENCY-2 down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CntW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rsp_err   <= ~access_ok;
        rsp_rdata <= (access_ok && !req_we) ? rdata_ext : 32'h0;
      end
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (accept && req_we && access_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench: three instances (LATENCY 1, 3, 4) against a byte-array reference model.
module tb_data_mem_unit;

  localparam int unsigned Depth = 1024;
  localparam int unsigned NInst = 3;

  logic        clk;
  logic        rst        [NInst];
  logic        req_valid  [NInst];
  logic        req_ready  [NInst];
  logic        req_we     [NInst];
  logic [1:0]  req_size   [NInst];
  logic        req_uns    [NInst];
  logic [31:0] req_addr   [NInst];
  logic [31:0] req_wdata  [NInst];
  logic        rsp_valid  [NInst];
  logic [31:0] rsp_rdata  [NInst];
  logic        rsp_err    [NInst];
  logic        busy       [NInst];

  logic [7:0] mm [NInst][4*Depth];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    data_mem_unit #(
      .MEM_DEPTH (Depth),
      .LATENCY   ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_uns[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g]),
      .busy         (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] model_word(input int d, input int w);
    return {mm[d][4*w+3], mm[d][4*w+2], mm[d][4*w+1], mm[d][4*w]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory with natural alignment rules.
  task automatic model_access(input int d, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic err);
    int unsigned nb;
    logic [31:0] v;
    nb    = 1 << size;
    err   = ((addr % nb) != 0) || (addr >= 4 * Depth);
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < int'(nb); i++) mm[d][addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < int'(nb); i++) v = v | (32'(mm[d][addr + i]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rdata = v;
      end
    end
  endtask

  task automatic do_req(input int d, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                        output logic [31:0] obs_rdata, output logic obs_err);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          n;
    logic        seen;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_size[d]  = size;
    req_uns[d]   = uns;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    model_access(d, we, size, uns, addr, wdata, exp_rdata, exp_err);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < lat_of(d) + 4) begin
      @(negedge clk);
      n++;
      seen = rsp_valid[d];
    end
    check({tag, ".lat"}, 32'(n), 32'(lat_of(d)));
    obs_rdata = rsp_rdata[d];
    obs_err   = rsp_err[d];
    if (seen) begin
      check({tag, ".rdata"}, rsp_rdata[d], exp_rdata);
      check({tag, ".err"}, 32'(rsp_err[d]), 32'(exp_err));
      @(negedge clk);
      check({tag, ".pulse"}, 32'(rsp_valid[d]), 32'd0);
      check({tag, ".reready"}, 32'(req_ready[d]), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] w;
    logic [31:0] exp_rd;
    logic        exp_er;
    logic [16:0] ready_obs, valid_obs, ready_exp, valid_exp;
    int          bad;
    int          seen_cnt;

    for (int d = 0; d < NInst; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_uns[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
    end

    for (int i = 0; i < int'(Depth); i++) begin
      for (int d = 0; d < NInst; d++) begin
        w = (i < 32) ? 32'h0 : $urandom();
        for (int b = 0; b < 4; b++) mm[d][4*i+b] = w[8*b +: 8];
      end
      g_dut[0].u_dut.mem[i] = model_word(0, i);
      g_dut[1].u_dut.mem[i] = model_word(1, i);
      g_dut[2].u_dut.mem[i] = model_word(2, i);
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < NInst; d++) begin
      check("rst.ready", 32'(req_ready[d]), 32'd1);
      check("rst.busy", 32'(busy[d]), 32'd0);
      check("rst.valid", 32'(rsp_valid[d]), 32'd0);
      check("rst.rdata", rsp_rdata[d], 32'h0);
      check("rst.err", 32'(rsp_err[d]), 32'd0);
      rst[d] = 1'b1;
    end

    // Directed single-cycle sequence.
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h0000_1234, "sw40", rd, er);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "lw40", rd, er);
    check("lw40.lit", rd, 32'h0000_1234);
    do_req(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_0080, "sb11", rd, er);
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, "lb11", rd, er);
    check("lb11.lit", rd, 32'hFFFF_FF80);
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, "lbu11", rd, er);
    check("lbu11.lit", rd, 32'h0000_0080);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10", rd, er);
    check("lw10.lit", rd, 32'h0000_8000);
    do_req(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF, "sh22", rd, er);
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "lh22", rd, er);
    check("lh22.lit", rd, 32'hFFFF_BEEF);
    do_req(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "lhu22", rd, er);
    check("lhu22.lit", rd, 32'h0000_BEEF);
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, "lw22", rd, er);
    check("lw22.err", 32'(er), 32'd1);
    check("lw22.zero", rd, 32'h0);
    check("mem20", g_dut[0].u_dut.mem[8], 32'hBEEF_0000);
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEAD_BEEF, "sw1000", rd, er);
    check("sw1000.err", 32'(er), 32'd1);

    // Back-to-back loads with req_valid held high on the LATENCY=3 instance.
    @(negedge clk);
    model_access(1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, exp_rd, exp_er);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = 2'd2;
    req_uns[1] = 1'b0; req_addr[1] = 32'h104;
    for (int k = 0; k <= 16; k++) begin
      ready_obs[k] = req_ready[1];
      valid_obs[k] = rsp_valid[1];
      ready_exp[k] = (k % 4 == 0);
      valid_exp[k] = (k % 4 == 3);
      if (rsp_valid[1]) check("b2b.rdata", rsp_rdata[1], exp_rd);
      if (k == 15) req_valid[1] = 1'b0;
      if (k < 16) @(negedge clk);
    end
    check("b2b.ready", 32'(ready_obs), 32'(ready_exp));
    check("b2b.valid", 32'(valid_obs), 32'(valid_exp));

    // Reset mid-flight on the LATENCY=4 instance.
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'd2;
    req_uns[2] = 1'b0; req_addr[2] = 32'h8; req_wdata[2] = 32'h0000_CAFE;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    model_access(2, 1'b1, 2'd2, 1'b0, 32'h8, 32'h0000_CAFE, exp_rd, exp_er);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst[2] = 1'b0;
    #1;
    check("mid.ready", 32'(req_ready[2]), 32'd1);
    check("mid.busy", 32'(busy[2]), 32'd0);
    check("mid.valid", 32'(rsp_valid[2]), 32'd0);
    check("mid.err", 32'(rsp_err[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b1;
    seen_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[2]) seen_cnt++;
    end
    check("mid.norsp", 32'(seen_cnt), 32'd0);
    do_req(2, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, "mid.lw8", rd, er);
    check("mid.lw8.lit", rd, 32'h0000_CAFE);

    // Randomized traffic on every instance.
    for (int d = 0; d < NInst; d++) begin
      for (int t = 0; t < 40; t++) begin
        logic [31:0] a;
        case ($urandom_range(0, 9))
          0:       a = 4 * Depth + $urandom_range(0, 64);
          1:       a = $urandom();
          default: a = 32'h100 + $urandom_range(0, 63);
        endcase
        do_req(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), a, $urandom(), "rnd", rd, er);
      end
    end

    bad = 0;
    for (int i = 0; i < int'(Depth); i++) if (g_dut[0].u_dut.mem[i] !== model_word(0, i)) bad++;
    check("mem.inst0", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < int'(Depth); i++) if (g_dut[1].u_dut.mem[i] !== model_word(1, i)) bad++;
    check("mem.inst1", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < int'(Depth); i++) if (g_dut[2].u_dut.mem[i] !== model_word(2, i)) bad++;
    check("mem.inst2", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised data-memory unit for the MIPS cores. It serves `lw/lh/lhu/lb/lbu/sw/sh/sb` through a valid/ready request port and a fixed-latency response port, so the single-cycle core (`LATENCY=1`) and the multi-cycle core (`LATENCY>1`) share one implementation. Misaligned and out-of-range accesses are flagged instead of silently corrupting memory. Benches preload and inspect it through the hierarchical array `mem`.

## Interface
- `MEM_DEPTH`, 1024, number of 32-bit words; legal byte addresses are 0 .. 4*MEM_DEPTH-1.
- `LATENCY`, 1, cycles from request acceptance to `rsp_valid`; must be ≥1 (elaboration error otherwise).
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  `mem_size_t`: byte, half or word.
- `req_unsigned`  in  1  load zero-extends (`lbu/lhu`); ignored for stores and words.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (`sb` uses [7:0], `sh` uses [15:0]).
- `rsp_valid`  out  1  one-cycle response strobe, for loads and stores.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  access was misaligned or out of range.
- `busy`  out  1  a request is in flight (`!req_ready`).

## Operation
- States: `IDLE`, `WAIT`, `RESP`.
- `IDLE`: `req_ready=1`. On `req_valid`, the request is accepted at that edge.
  - Go to `RESP` if `LATENCY==1`.
  - Otherwise go to `WAIT` and load a down-counter with `LATENCY-2`.
- `WAIT`: decrement the counter. Go to `RESP` after the edge where the counter is 0.
- `RESP`: drive `rsp_valid=1` for exactly one cycle, then return to `IDLE`.
- Commit point is the acceptance edge:
  - Stores write the byte lanes at that edge.
  - Loads capture and extend the data at that edge into a response register.
  - A load following a store therefore always sees the stored data.
- Byte order is little-endian: lane = `addr[1:0]`; a half occupies lanes {`addr[1]`*2, +1}.
- Alignment rule: half needs `addr[0]==0`; word needs `addr[1:0]==0`.
- Range rule: `addr[31:2] >= MEM_DEPTH` is out of range.
- On a misaligned or out-of-range request:
  - no write occurs;
  - the response still arrives after `LATENCY` cycles;
  - `rsp_err=1` and `rsp_rdata=0`.
- Load extension: `lb/lh` sign-extend from bit 7/15; `lbu/lhu` zero-extend.
- Requests presented while busy are not accepted. The requester holds them stable until `req_ready`.
- `mem` contents are not affected by reset.

## Timing
- Reset values: state `IDLE`, `req_ready=1`, `busy=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, counter 0.
- Request accepted at edge T → `rsp_valid` high during the cycle after edge T+`LATENCY`-1, i.e. `LATENCY` cycles after acceptance.
- `req_ready` returns high in the cycle after `rsp_valid`.
- Maximum throughput is one request per `LATENCY+1` cycles.
- `rsp_rdata`/`rsp_err` are registered and valid only while `rsp_valid=1`. They hold their last values otherwise.
- Reset asserted mid-operation:
  - the pending response is dropped and outputs return immediately to their reset values;
  - a store already accepted stays written.
- `req_valid` with `req_ready=0` has no effect. No request is queued.

## Structure
- `mem_pkg`:
  - `typedef enum logic [1:0] {SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2} mem_size_t;`
  - the FSM state enum `dmu_state_t`;
  - the function `is_aligned(addr, size)`.
- Sub-module `mem_lane_align` (combinational):
  - store path: produces the 4-bit byte-write mask and the lane-shifted write data;
  - load path: extracts and sign/zero-extends from the read word.
- Top: FSM, latency counter, `mem` array (`logic [31:0] mem [0:MEM_DEPTH-1]`), response registers.

## Test plan
- `LATENCY=1`: `sw` 0x00001234 → addr 0x40, then `lw` 0x40 → `rsp_rdata=0x00001234`, `rsp_err=0`, each `rsp_valid` exactly 1 cycle after acceptance.
- `sb` 0x80 → addr 0x11, then:
  - `lb` 0x11 → 0xFFFFFF80;
  - `lbu` 0x11 → 0x00000080;
  - `lw` 0x10 → 0x00008000 (the word at 0x10 was zero beforehand).
- `sh` 0xBEEF → addr 0x22, then `lh` 0x22 → 0xFFFFBEEF and `lhu` 0x22 → 0x0000BEEF. A `lw` at 0x22 → `rsp_err=1`, `rsp_rdata=0`, memory unchanged.
- `LATENCY=3`, with `req_valid` held high for 4 back-to-back loads:
  - `rsp_valid` pulses every 4 cycles;
  - `req_ready` is low for 3 cycles after each acceptance.
- `MEM_DEPTH=1024`: `sw` to 0x1000 → `rsp_err=1`, and no word of `mem` changes.
- `LATENCY=4`: `sw` 0xCAFE → 0x8, pull `reset` low 2 cycles after acceptance, release it.
  - No `rsp_valid` appears; `req_ready=1` immediately.
  - A subsequent `lw` 0x8 returns 0x0000CAFE.
